// File: rtl/sram_to_sram_pkg.sv
// Shared types and default sizing for the SRAM-to-SRAM transfer sequencer.
package sram_to_sram_pkg;

   localparam int unsigned ADDR_BITS_DEFAULT  = 10;
   localparam int unsigned DATA_BITS_DEFAULT  = 64;
   localparam int unsigned RD_LATENCY_DEFAULT = 2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRead = 2'd1,
      StWait = 2'd2
   } state_t;

endpackage

// File: rtl/sram_to_sram_delay.sv
// Clock-enabled shift register with asynchronous active-low clear.
module sram_to_sram_delay #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cke_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Depth-1:0][Width-1:0] pipe_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_q <= '0;
      end else if (cke_i) begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < Depth; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/sram_to_sram_ctrl.sv
// Reads both source SRAMs in address order, streams the words to the write stage,
// then waits for the write stage to finish or times out.
module sram_to_sram_ctrl
   import sram_to_sram_pkg::*;
#(
   parameter int unsigned ADDR_BITS  = ADDR_BITS_DEFAULT,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT,
   parameter int unsigned RD_LATENCY = RD_LATENCY_DEFAULT,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cke_i,
   input  logic                 start_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   output logic                 mem0_ren_o,
   output logic                 mem1_ren_o,
   output logic [ADDR_BITS-1:0] mem0_raddr_o,
   output logic [ADDR_BITS-1:0] mem1_raddr_o,
   input  logic [DATA_BITS-1:0] mem0_rdata_i,
   input  logic [DATA_BITS-1:0] mem1_rdata_i,
   output logic [DATA_BITS-1:0] m_data0_o,
   output logic [DATA_BITS-1:0] m_data1_o,
   output logic                 m_valid_o,
   input  logic                 wr_done_i
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef logic [ADDR_BITS-1:0] addr_t;

   state_t          state_q, state_d;
   addr_t           raddr_q, raddr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic            wr_seen_q, wr_seen_d;
   logic            read_en;

   always_comb begin
      state_d   = state_q;
      raddr_d   = raddr_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      error_d   = error_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StRead;
               raddr_d = '0;
               error_d = 1'b0;
            end
         end
         StRead: begin
            // Wraps to 0 after the last word, matching the write stage's counter.
            raddr_d = raddr_q + 1'b1;
            if (raddr_q == '1) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            if (wr_done_i || wr_seen_q) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      // A wr_done that arrives before WAIT must not be lost; it is dropped in IDLE.
      if (state_q != StIdle && state_d != StIdle) begin
         wr_seen_d = wr_seen_q | wr_done_i;
      end else begin
         wr_seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         raddr_q   <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         wr_seen_q <= 1'b0;
      end else if (cke_i) begin
         state_q   <= state_d;
         raddr_q   <= raddr_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         error_q   <= error_d;
         wr_seen_q <= wr_seen_d;
      end
   end

   assign read_en      = (state_q == StRead);
   assign busy_o       = (state_q != StIdle);
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign mem0_ren_o   = read_en;
   assign mem1_ren_o   = read_en;
   assign mem0_raddr_o = raddr_q;
   assign mem1_raddr_o = raddr_q;
   assign m_data0_o    = mem0_rdata_i;
   assign m_data1_o    = mem1_rdata_i;

   sram_to_sram_delay #(
      .Depth (RD_LATENCY),
      .Width (1)
   ) u_valid_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .cke_i   (cke_i),
      .d_i     (read_en),
      .q_o     (m_valid_o)
   );

endmodule

// File: tb/tb_sram_to_sram_ctrl.sv
// Directed bench for sram_to_sram_ctrl with 16-word behavioural source SRAMs.
module tb_sram_to_sram_ctrl;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 64;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic          cke     = 1'b1;
   logic          start   = 1'b0;
   logic          wr_done = 1'b0;
   logic          busy, done, error;
   logic          mem0_ren, mem1_ren, m_valid;
   logic [AW-1:0] mem0_raddr, mem1_raddr;
   logic [DW-1:0] mem0_rdata, mem1_rdata, m_data0, m_data1;

   logic [DW-1:0] mem0 [16];
   logic [DW-1:0] mem1 [16];
   logic [DW-1:0] rd0_s0, rd0_s1, rd1_s0, rd1_s1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Two-cycle read latency; the SRAM clock is gated by cke like the rest of the datapath.
   always @(posedge clk) begin
      if (cke) begin
         if (mem0_ren) rd0_s0 <= mem0[mem0_raddr];
         if (mem1_ren) rd1_s0 <= mem1[mem1_raddr];
         rd0_s1 <= rd0_s0;
         rd1_s1 <= rd1_s0;
      end
   end
   assign mem0_rdata = rd0_s1;
   assign mem1_rdata = rd1_s1;

   sram_to_sram_ctrl #(
      .ADDR_BITS  (AW),
      .DATA_BITS  (DW),
      .RD_LATENCY (2),
      .TIMEOUT    (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cke_i        (cke),
      .start_i      (start),
      .busy_o       (busy),
      .done_o       (done),
      .error_o      (error),
      .mem0_ren_o   (mem0_ren),
      .mem1_ren_o   (mem1_ren),
      .mem0_raddr_o (mem0_raddr),
      .mem1_raddr_o (mem1_raddr),
      .mem0_rdata_i (mem0_rdata),
      .mem1_rdata_i (mem1_rdata),
      .m_data0_o    (m_data0),
      .m_data1_o    (m_data1),
      .m_valid_o    (m_valid),
      .wr_done_i    (wr_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Maps a real cycle to the controller's progress when cke is low in cycles 5..7.
   function automatic int eff(input int c, input bit stall);
      if (!stall || c < 5) return c;
      if (c < 8) return 5;
      return c - 3;
   endfunction

   // Starts a transfer in the current cycle (cycle 0) and checks every cycle up to last.
   // wr_at < 0 means wr_done never arrives, so a timeout is expected.
   task automatic run_xfer(input bit stall, input int wr_at, input int extra_start,
                           input bit prev_err, input int last);
      int e, wr_e, end_e;
      bit err, exp_ren, exp_valid;
      int exp_addr;
      err   = (wr_at < 0);
      wr_e  = err ? 0 : eff(wr_at, stall);
      end_e = err ? 25 : ((wr_e + 1 > 18) ? wr_e + 1 : 18);
      for (int c = 0; c <= last; c++) begin
         e         = eff(c, stall);
         start     = (c == 0) || (c == extra_start);
         cke       = !(stall && c >= 5 && c <= 7);
         wr_done   = (c == wr_at);
         exp_ren   = (e >= 1 && e <= 16);
         exp_addr  = exp_ren ? e - 1 : 0;
         exp_valid = (e >= 3 && e <= 18);
         chk("ren", 64'({mem0_ren, mem1_ren}), 64'({exp_ren, exp_ren}));
         chk("raddr", 64'({mem0_raddr, mem1_raddr}), 64'({AW'(exp_addr), AW'(exp_addr)}));
         chk("m_valid", 64'(m_valid), 64'(exp_valid));
         if (exp_valid) begin
            chk("m_data0", m_data0, 64'(e - 3));
            chk("m_data1", m_data1, 64'(32'h100 + e - 3));
         end
         chk("busy", 64'(busy), 64'(e >= 1 && e < end_e));
         chk("done", 64'(done), 64'(!err && e == end_e));
         chk("error", 64'(error), 64'((e == 0) ? prev_err : (err && e >= end_e)));
         if (c < last) tick();
      end
      start   = 1'b0;
      wr_done = 1'b0;
      cke     = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < 16; a++) begin
         mem0[a] = 64'(a);
         mem1[a] = 64'(32'h100 + a);
      end

      // Reset values while held in reset
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_ren", 64'({mem0_ren, mem1_ren}), 64'd0);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_raddr", 64'(mem0_raddr), 64'd0);
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      tick();
      tick();
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_ren", 64'(mem0_ren), 64'd0);

      // Basic transfer: done at 21
      run_xfer(1'b0, 20, -1, 1'b0, 22);
      // Stall in cycles 5..7: everything shifts by 3
      run_xfer(1'b1, 23, -1, 1'b0, 25);
      // Second start during READ ignored, then back-to-back start the cycle after done
      run_xfer(1'b0, 20, 8, 1'b0, 22);
      run_xfer(1'b0, 20, -1, 1'b0, 22);
      // wr_done during READ is remembered and completes on the first WAIT cycle
      run_xfer(1'b0, 10, -1, 1'b0, 20);
      // Timeout, then a new start clears error
      run_xfer(1'b0, -1, -1, 1'b0, 27);
      run_xfer(1'b0, 20, -1, 1'b1, 22);

      // Reset mid-transfer
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_busy_pre", 64'(busy), 64'd1);
      chk("mid_valid_pre", 64'(m_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_ren", 64'({mem0_ren, mem1_ren}), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_valid", 64'(m_valid), 64'd0);
      chk("mid_raddr", 64'(mem0_raddr), 64'd0);
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      run_xfer(1'b0, 20, -1, 1'b0, 22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_to_sram_ctrl.md
# sram_to_sram_ctrl

Transfer sequencer for the SRAM-to-SRAM evaluation datapath. On `start` it reads every word of the two source SRAMs (mem0, mem1) in address order and streams the read data to the write stage as `m_data0`/`m_data1`/`m_valid`. It then waits for the write stage's `done`, reports completion or a timeout, and returns to idle. It sits between the source SRAM read ports and the write stage's `s_*` inputs.

## Interface
- `ADDR_BITS`, 10, SRAM address width; one transfer is always 2^ADDR_BITS words.
- `addr_t`, `logic [ADDR_BITS-1:0]`, address type.
- `DATA_BITS`, 64, SRAM word width.
- `data_t`, `logic [DATA_BITS-1:0]`, data type.
- `RD_LATENCY`, 2, source SRAM read latency in cycles (≥1).
- `TIMEOUT`, 64, cycles allowed in WAIT for `wr_done` (≥1).

Ports:
- `reset_n` in 1: reset, asynchronous, active-low (**already decided**).
- `clk` in 1: single clock; all logic is in this domain (**already decided**).
- `cke` in 1: clock enable; state and registers advance only when `cke` is 1.
- `start` in 1: transfer request, sampled in IDLE.
- `busy` out 1: high in READ and WAIT.
- `done` out 1: one-cke-cycle completion pulse.
- `error` out 1: sticky timeout flag; cleared by an accepted `start`.
- `mem0_ren` / `mem1_ren` out 1: source read enables.
- `mem0_raddr` / `mem1_raddr` out ADDR_BITS: source read addresses.
- `mem0_rdata` / `mem1_rdata` in DATA_BITS: source read data, valid RD_LATENCY cycles after `ren`.
- `m_data0` / `m_data1` out DATA_BITS: stream to the write stage.
- `m_valid` out 1: stream valid.
- `wr_done` in 1: write stage completion.

## Operation
- FSM states: IDLE, READ, WAIT.
- **IDLE**
  - `start`=1 → READ; `raddr`←0; `error`←0.
- **READ**
  - `ren`=1 each cke cycle; `raddr` increments.
  - When `raddr`=='1 is issued → WAIT; timeout counter ← 0.
  - `start` is ignored.
- **WAIT**
  - `ren`=0.
  - `wr_done` (or the sticky `wr_done` seen during READ) → `done`=1, then IDLE.
  - Counter reaching TIMEOUT → `error`=1, then IDLE with no `done`.
- Read enables are combinational from the state: `mem0_ren`=`mem1_ren`=(state==READ). `mem0_raddr`=`mem1_raddr`=the same registered address.
- Valid pipeline: an RD_LATENCY-deep shift register of `ren`. `m_valid`=tail of the shift register.
- `m_data0`=`mem0_rdata` and `m_data1`=`mem1_rdata`, passed through combinationally. Data is don't-care when `m_valid`=0.
- The address counter wraps naturally at '1. There is no partial-length transfer, so it stays aligned with the write stage's free-running address counter.
- `wr_done` is captured into a sticky flag from READ onward and cleared on entry to IDLE.
- If `start` and `wr_done` arrive together in IDLE, `start` is honoured and `wr_done` is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `ren`, `m_valid` all 0; `raddr` 0; valid pipeline cleared.
- Assertion of `reset_n` mid-transfer clears everything immediately. The write stage must share the same reset.
- `start` sampled at edge k → `ren` and `busy` high from cycle k+1. First `m_valid` at k+1+RD_LATENCY.
- With no stalls, READ lasts exactly 2^ADDR_BITS cycles. `done` is asserted the cycle after `wr_done` is sampled, and `busy` drops in that same cycle.
- `cke`=0 freezes the FSM, address, valid pipeline, timeout counter and `done`/`error`. Outputs hold their values.
- Timeout counter width: $clog2(TIMEOUT+1).

## Structure
- `sram_to_sram_pkg` holds:
  - `state_t` enum (IDLE/READ/WAIT);
  - default constants `ADDR_BITS_DEFAULT`=10, `DATA_BITS_DEFAULT`=64, `RD_LATENCY_DEFAULT`=2.
- Sub-module `sram_to_sram_delay`: parameterised cke-gated shift register (depth RD_LATENCY, width 1) with async active-low clear. It is used for the valid pipeline.

## Test plan
Common setup: ADDR_BITS=4, RD_LATENCY=2, source memories loaded with mem0[a]=a and mem1[a]=0x100+a, connected to the real write stage.

- **Reset:** hold `reset_n`=0 → all outputs 0. Release with `start`=0 → remains IDLE, `busy`=0.
- **Basic transfer:** `start` pulse at cycle 0 →
  - `ren` high in cycles 1–16 with addresses 0–15;
  - `m_valid` high in cycles 3–18 with `m_data0` 0–15 and `m_data1` 0x100–0x10F;
  - `wr_done` at cycle 20, `done` at cycle 21, `busy`=0 at cycle 21;
  - mem2/mem3 contents match the sources.
- **Stall:** `cke`=0 for cycles 5–7 → address holds at 4. Stream and `done` shift by exactly 3 cycles; data is unchanged.
- **Start while busy:** `start` pulses at cycles 0 and 8 → only one transfer occurs and `done` pulses once. A back-to-back `start` in the `done` cycle+1 runs a second correct transfer.
- **Timeout:** tie `wr_done`=0, TIMEOUT=8 → `error`=1 eight cycles after WAIT is entered. No `done`; state returns to IDLE. The next `start` clears `error`.
- **Reset mid-transfer:** drop `reset_n` during cycle 6 → `ren`, `busy` and `m_valid` go to 0 asynchronously. After release, a new `start` completes normally.
